// File: rtl/tinyalu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tinyalu_cmd_issuer
// Purpose  : Buffers ALU commands in a FIFO and drives the TinyALU
//            start/done protocol, returning each result on a response port.
// Revision : 1.0 - initial release
// ============================================================================
module tinyalu_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [7:0]                 cmd_a,
  input  logic [7:0]                 cmd_b,
  input  logic [2:0]                 cmd_op,
  output logic [7:0]                 alu_a,
  output logic [7:0]                 alu_b,
  output logic [2:0]                 alu_op,
  output logic                       alu_start,
  output logic                       alu_reset_n,
  input  logic                       alu_done,
  input  logic [15:0]                alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [15:0]                rsp_result,
  output logic [2:0]                 rsp_op,
  output logic                       rsp_timeout,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       busy
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam int c_TMO_W = $clog2(TIMEOUT);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ISSUE = 3'd1;
  localparam logic [2:0] c_NOP   = 3'd2;
  localparam logic [2:0] c_RST   = 3'd3;
  localparam logic [2:0] c_RESP  = 3'd4;

  logic [18:0]        r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [2:0]         r_state;
  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic [7:0]         r_alu_a;
  logic [7:0]         r_alu_b;
  logic [2:0]         r_alu_op;
  logic               r_alu_start;
  logic               r_alu_reset_n;
  logic [15:0]        r_rsp_result;
  logic [2:0]         r_rsp_op;
  logic               r_rsp_timeout;

  logic               w_push;
  logic               w_pop;
  logic [18:0]        w_head;
  logic [2:0]         w_head_op;

  assign cmd_ready = (r_count < c_CNT_W'(DEPTH));
  assign w_push    = cmd_valid && cmd_ready;
  assign w_pop     = (r_state == c_IDLE) && (r_count != '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_op = w_head[18:16];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_op, cmd_a, cmd_b};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_IDLE;
      r_tmo_cnt     <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_alu_start   <= 1'b0;
      r_alu_reset_n <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_op      <= '0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_alu_reset_n <= 1'b1;
      case (r_state)
        c_IDLE: begin
          if (w_pop) begin
            r_alu_a       <= w_head[15:8];
            r_alu_b       <= w_head[7:0];
            r_rsp_op      <= w_head_op;
            r_rsp_timeout <= 1'b0;
            r_tmo_cnt     <= '0;
            case (w_head_op)
              3'd1, 3'd2, 3'd3, 3'd4: begin
                r_alu_op    <= w_head_op;
                r_alu_start <= 1'b1;
                r_state     <= c_ISSUE;
              end
              3'd7: begin
                r_alu_op      <= w_head_op;
                r_alu_start   <= 1'b0;
                r_alu_reset_n <= 1'b0;
                r_state       <= c_RST;
              end
              // no_op and the reserved codes run as a one-cycle no_op.
              default: begin
                r_alu_op    <= 3'd0;
                r_alu_start <= 1'b1;
                r_state     <= c_NOP;
              end
            endcase
          end
        end
        c_ISSUE: begin
          if (alu_done) begin
            r_rsp_result <= alu_result;
            r_alu_start  <= 1'b0;
            r_state      <= c_RESP;
          end else if (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1)) begin
            r_rsp_result  <= '0;
            r_rsp_timeout <= 1'b1;
            r_alu_start   <= 1'b0;
            r_state       <= c_RESP;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
          end
        end
        c_NOP: begin
          r_alu_start  <= 1'b0;
          r_rsp_result <= '0;
          r_state      <= c_RESP;
        end
        c_RST: begin
          // Second RST cycle releases the ALU reset on its closing edge.
          if (r_tmo_cnt == '0) begin
            r_alu_reset_n <= 1'b0;
            r_tmo_cnt     <= c_TMO_W'(1);
          end else begin
            r_rsp_result <= '0;
            r_state      <= c_RESP;
          end
        end
        c_RESP: begin
          if (rsp_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign alu_start   = r_alu_start;
  assign alu_reset_n = r_alu_reset_n;
  assign rsp_valid   = (r_state == c_RESP);
  assign rsp_result  = r_rsp_result;
  assign rsp_op      = r_rsp_op;
  assign rsp_timeout = r_rsp_timeout;
  assign level       = r_count;
  assign busy        = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tinyalu_cmd_issuer
// Purpose  : Directed self-checking bench with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tinyalu_cmd_issuer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_reset_n;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic [2:0]  level;
  logic        busy;

  tinyalu_cmd_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_start(alu_start), .alu_reset_n(alu_reset_n),
    .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
    .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] r;
    case (op)
      3'd1:    r = 16'(a) + 16'(b);
      3'd2:    r = {8'h00, a & b};
      3'd3:    r = {8'h00, a ^ b};
      3'd4:    r = 16'(a) * 16'(b);
      default: r = 16'h0000;
    endcase
    return r;
  endfunction

  // Transaction-level model: a queue of pending commands, the one in flight,
  // and the response waiting to be taken.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  cmd_t        mq[$];
  cmd_t        m_cur      = '0;
  bit          m_in_reset = 1'b1;
  bit          m_active   = 1'b0;
  bit          m_rsp      = 1'b0;
  int          m_exec     = 0;
  logic [15:0] m_res      = '0;
  bit          m_to       = 1'b0;
  logic [2:0]  m_rsp_op   = '0;
  logic [7:0]  m_a        = '0;
  logic [7:0]  m_b        = '0;
  logic [2:0]  m_op       = '0;

  always @(posedge clk) begin : model
    bit   room;
    cmd_t c;
    room = (mq.size() < DEPTH);
    if (reset) begin
      mq.delete();
      m_in_reset = 1'b1;
      m_active   = 1'b0;
      m_rsp      = 1'b0;
      m_a = '0; m_b = '0; m_op = '0;
      m_res = '0; m_to = 1'b0; m_rsp_op = '0;
    end else begin
      m_in_reset = 1'b0;
      if (m_rsp) begin
        if (rsp_ready) m_rsp = 1'b0;
      end else if (m_active) begin
        m_exec++;
        if (m_cur.op == 3'd7) begin
          if (m_exec == 2) begin m_active = 1'b0; m_rsp = 1'b1; m_res = '0; m_to = 1'b0; end
        end else if (m_cur.op inside {[3'd1:3'd4]}) begin
          if (alu_done) begin
            m_active = 1'b0; m_rsp = 1'b1; m_res = alu_fn(m_cur.op, m_cur.a, m_cur.b); m_to = 1'b0;
          end else if (m_exec == TIMEOUT) begin
            m_active = 1'b0; m_rsp = 1'b1; m_res = '0; m_to = 1'b1;
          end
        end else begin
          m_active = 1'b0; m_rsp = 1'b1; m_res = '0; m_to = 1'b0;
        end
      end else if (mq.size() > 0) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_exec   = 0;
        m_a      = m_cur.a;
        m_b      = m_cur.b;
        m_op     = (m_cur.op inside {[3'd1:3'd4], 3'd7}) ? m_cur.op : 3'd0;
        m_rsp_op = m_cur.op;
      end
      if (cmd_valid && room) begin
        c.a = cmd_a; c.b = cmd_b; c.op = cmd_op;
        mq.push_back(c);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_ready",   32'(cmd_ready),   32'(mq.size() < DEPTH));
      check("level",       32'(level),       32'(mq.size()));
      check("busy",        32'(busy),        32'(m_active || m_rsp));
      check("alu_start",   32'(alu_start),   32'(m_active && (m_cur.op != 3'd7)));
      check("alu_reset_n", 32'(alu_reset_n), 32'(!m_in_reset && !(m_active && (m_cur.op == 3'd7))));
      check("alu_a",       32'(alu_a),       32'(m_a));
      check("alu_b",       32'(alu_b),       32'(m_b));
      check("alu_op",      32'(alu_op),      32'(m_op));
      check("rsp_valid",   32'(rsp_valid),   32'(m_rsp));
      if (m_rsp) begin
        check("rsp_result",  32'(rsp_result),  32'(m_res));
        check("rsp_op",      32'(rsp_op),      32'(m_rsp_op));
        check("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
      end
    end
  end

  // ALU stand-in: answers arithmetic ops after lat start cycles; lat 0 never answers.
  int lat  = 1;
  int rcnt = 0;
  always @(posedge clk) begin
    #1;
    alu_done   = 1'b0;
    alu_result = 16'hBAD0;
    if (alu_start && (alu_op inside {[3'd1:3'd4]})) begin
      rcnt++;
      if (lat != 0 && rcnt == lat) begin
        alu_done   = 1'b1;
        alu_result = alu_fn(alu_op, alu_a, alu_b);
      end
    end else begin
      rcnt = 0;
    end
  end

  int start_cnt = 0;
  int rstn_cnt  = 0;
  int rsp_cnt   = 0;
  always @(negedge clk) begin
    if (alu_start) start_cnt++;
    if (!reset && !alu_reset_n) rstn_cnt++;
    if (rsp_valid && rsp_ready) rsp_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: actual not accepted, required accepted (op %0d)", op);
    end
  endtask

  task automatic wait_rsp(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_wait: actual no response, required response", name);
    end
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = !busy && (level == 0) && !rsp_valid;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_idle: actual still busy, required idle", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual simulation still running, required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b1; alu_done = 1'b0; alu_result = '0;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
    check("rst_level",       32'(level),       32'd0);
    check("rst_alu_reset_n", 32'(alu_reset_n), 32'd0);
    check("rst_rsp_result",  32'(rsp_result),  32'd0);
    check("rst_rsp_op",      32'(rsp_op),      32'd0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("rel_alu_reset_n", 32'(alu_reset_n), 32'd1);

    // add FF+01
    tick();
    lat = 1; start_cnt = 0;
    push(3'd1, 8'hFF, 8'h01);
    wait_rsp("add");
    check("add_result",  32'(rsp_result),  32'h0100);
    check("add_op",      32'(rsp_op),      32'd1);
    check("add_timeout", 32'(rsp_timeout), 32'd0);
    wait_idle("add");
    check("add_start_cycles", 32'(start_cnt), 32'd1);

    // mul FF*FF with a 3-cycle ALU
    tick();
    lat = 3; start_cnt = 0;
    push(3'd4, 8'hFF, 8'hFF);
    wait_rsp("mul");
    check("mul_result", 32'(rsp_result), 32'hFE01);
    wait_idle("mul");
    check("mul_start_cycles", 32'(start_cnt), 32'd3);

    // fill the FIFO behind a stalled response
    tick();
    lat = 1; rsp_ready = 1'b0; rsp_cnt = 0;
    push(3'd1, 8'h10, 8'h20);
    push(3'd2, 8'hF0, 8'h3C);
    push(3'd3, 8'hF0, 8'h3C);
    push(3'd4, 8'h12, 8'h34);
    push(3'd1, 8'h80, 8'h80);
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 8'hAA; cmd_b = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      check("full_level",     32'(level),     32'd4);
      tick();
    end
    rsp_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    check("sixth_push_accepted", 32'(ok), 32'd1);
    wait_idle("drain");
    check("drain_rsp_count", 32'(rsp_cnt), 32'd6);

    // rst_op, no_op, reserved op
    tick();
    rstn_cnt = 0; start_cnt = 0;
    push(3'd7, 8'h11, 8'h22);
    wait_rsp("rstop");
    check("rstop_op",     32'(rsp_op),     32'd7);
    check("rstop_result", 32'(rsp_result), 32'd0);
    tick();
    push(3'd0, 8'h33, 8'h44);
    wait_rsp("noop");
    check("noop_op",     32'(rsp_op),     32'd0);
    check("noop_result", 32'(rsp_result), 32'd0);
    tick();
    push(3'd5, 8'h01, 8'h02);
    wait_idle("misc");
    check("rstop_low_cycles",  32'(rstn_cnt),  32'd2);
    check("nop_start_cycles",  32'(start_cnt), 32'd2);

    // timeout, then the next queued command runs normally
    tick();
    lat = 0; rsp_ready = 1'b0; start_cnt = 0;
    push(3'd1, 8'h05, 8'h06);
    push(3'd3, 8'h0F, 8'hF0);
    wait_rsp("tmo");
    check("tmo_flag",         32'(rsp_timeout), 32'd1);
    check("tmo_result",       32'(rsp_result),  32'd0);
    check("tmo_start_cycles", 32'(start_cnt),   32'd16);
    tick();
    lat = 2; rsp_ready = 1'b1;
    wait_idle("tmo");
    check("after_tmo_start_cycles", 32'(start_cnt), 32'd18);

    // reset while in ISSUE with commands queued
    tick();
    lat = 0; rsp_ready = 1'b1;
    push(3'd1, 8'h01, 8'h01);
    push(3'd2, 8'h02, 8'h02);
    push(3'd3, 8'h03, 8'h03);
    tick();
    @(negedge clk);
    check("pre_reset_busy",  32'(busy),  32'd1);
    check("pre_reset_level", 32'(level), 32'd2);
    tick();
    rsp_cnt = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_level",     32'(level),       32'd0);
    check("abort_busy",      32'(busy),        32'd0);
    check("abort_alu_start", 32'(alu_start),   32'd0);
    check("abort_alu_a",     32'(alu_a),       32'd0);
    check("abort_reset_n",   32'(alu_reset_n), 32'd0);
    lat = 1;
    repeat (40) tick();
    check("abort_no_response", 32'(rsp_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
